// File: rtl/vga_text_arbiter_if.sv
// CPU-side load/store bus into the text RAM arbiter.
// master = CPU requester, slave = arbiter.
interface vga_text_arbiter_if #(
   parameter int AW = 12
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_ack;
   logic [7:0]    cpu_rdata;

   modport master (
      output cpu_req,
      output cpu_we,
      output cpu_addr,
      output cpu_wdata,
      input  cpu_ack,
      input  cpu_rdata
   );

   modport slave (
      input  cpu_req,
      input  cpu_we,
      input  cpu_addr,
      input  cpu_wdata,
      output cpu_ack,
      output cpu_rdata
   );
endinterface

// File: rtl/vga_text_arbiter.sv
// Text RAM port arbiter: display > clear sequencer > CPU.
// Optional CPU stall counter enabled by VGA_ARB_STATS_EN.
module vga_text_arbiter #(
   parameter int         COLS     = 70,
   parameter int         ROWS     = 30,
   parameter int         AW       = 12,
   parameter logic [7:0] CLR_CHAR = 8'h20
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_valid,
   output logic [7:0]    disp_data,
   vga_text_arbiter_if.slave cpu_bus,
   input  logic          clr_start,
   output logic          clr_done,
   output logic          busy,
   output logic [15:0]   stall_cnt,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata
);

   localparam int            CELLS   = COLS * ROWS;
   localparam logic [AW:0]   CELLS_W = (AW+1)'(CELLS);
   localparam logic [AW-1:0] LAST    = AW'(CELLS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CPU_DONE,
      CLEAR
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] clr_cnt;
   logic [AW-1:0] clr_cnt_nxt;
   logic [AW-1:0] addr_q;

   logic gnt_disp;
   logic gnt_clr;
   logic gnt_cpu;
   logic clr_last;
   logic disp_oor;
   logic cpu_oor;

   logic disp_v_q;
   logic disp_oor_q;
   logic ack_q;
   logic rd_ok_q;
   logic done_q;

   assign disp_oor = {1'b0, disp_addr} >= CELLS_W;
   assign cpu_oor  = {1'b0, cpu_bus.cpu_addr} >= CELLS_W;

   // Next state, clear counter and per-cycle grant decision
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      gnt_disp    = disp_req;
      gnt_clr     = 1'b0;
      gnt_cpu     = 1'b0;
      clr_last    = 1'b0;
      unique case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end else if (!disp_req && cpu_bus.cpu_req) begin
               gnt_cpu   = 1'b1;
               state_nxt = CPU_DONE;
            end
         end
         CPU_DONE: begin
            if (clr_start) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         CLEAR: begin
            if (!disp_req) begin
               gnt_clr = 1'b1;
               if (clr_cnt == LAST) begin
                  state_nxt   = IDLE;
                  clr_cnt_nxt = '0;
                  clr_last    = 1'b1;
               end else begin
                  clr_cnt_nxt = clr_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM port mux; address holds when nobody owns the port
   always_comb begin
      ram_addr  = addr_q;
      ram_we    = 1'b0;
      ram_wdata = '0;
      unique case (1'b1)
         gnt_disp: ram_addr = disp_addr;
         gnt_clr: begin
            ram_addr  = clr_cnt;
            ram_we    = 1'b1;
            ram_wdata = CLR_CHAR;
         end
         gnt_cpu: begin
            ram_addr  = cpu_bus.cpu_addr;
            ram_we    = cpu_bus.cpu_we && !cpu_oor;
            ram_wdata = cpu_bus.cpu_wdata;
         end
         default: ;
      endcase
      if (!reset_n) ram_we = 1'b0;
   end

   // FSM state, clear counter and held RAM address
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         clr_cnt <= '0;
         addr_q  <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         addr_q  <= ram_addr;
      end
   end

   // Registered completion flags aligned to RAM read latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp_v_q   <= 1'b0;
         disp_oor_q <= 1'b0;
         ack_q      <= 1'b0;
         rd_ok_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         disp_v_q   <= gnt_disp;
         disp_oor_q <= disp_oor;
         ack_q      <= gnt_cpu;
         rd_ok_q    <= gnt_cpu && !cpu_bus.cpu_we && !cpu_oor;
         done_q     <= clr_last;
      end
   end

   assign disp_valid = disp_v_q;
   assign disp_data  = (disp_v_q && !disp_oor_q) ? ram_rdata : 8'h00;
   assign cpu_bus.cpu_ack   = ack_q;
   assign cpu_bus.cpu_rdata = (ack_q && rd_ok_q) ? ram_rdata : 8'h00;
   assign clr_done   = done_q;
   assign busy       = (state == CLEAR);

`ifdef VGA_ARB_STATS_EN
   logic [15:0] stall_q;

   // Saturating count of cycles the CPU waits for the port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else if (cpu_bus.cpu_req && !gnt_cpu &&
                   (state != CPU_DONE) && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
